// File: rtl/equality_checker.sv
// N-bit equality comparator with combinational eq/neq/lowest-differing-bit outputs and a one-cycle registered copy.
// Optional sticky mismatch flag is enabled by defining EQUALITY_CHECKER_STICKY_EN.
module equality_checker #(
    parameter  int N    = 32,
    localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    input  logic            in_valid,
`ifdef EQUALITY_CHECKER_STICKY_EN
    input  logic            sticky_clr,
    output logic            sticky_neq,
`endif
    output logic            eq,
    output logic            neq,
    output logic [IDXW-1:0] diff_idx,
    output logic            eq_q,
    output logic            neq_q,
    output logic [IDXW-1:0] idx_q,
    output logic            out_valid
);

    // Lowest set bit wins; scanning from the top lets lower bits overwrite.
    function automatic logic [IDXW-1:0] lowest_set(input logic [N-1:0] v);
        logic [IDXW-1:0] idx;
        idx = {IDXW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[IDXW-1:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [N-1:0]    xor_s;
    logic            eq_s;
    logic            neq_s;
    logic [IDXW-1:0] idx_s;

    logic            eq_r;
    logic            neq_r;
    logic [IDXW-1:0] idx_r;
    logic            valid_r;

    // Compare path: purely combinational, independent of clk/rst.
    always_comb begin
        xor_s = a ^ b;
        neq_s = |xor_s;
        eq_s  = ~neq_s;
        idx_s = lowest_set(xor_s);
    end

    assign eq       = eq_s;
    assign neq      = neq_s;
    assign diff_idx = idx_s;

    // Result register: captures the compare of each qualified sample, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            eq_r    <= 1'b0;
            neq_r   <= 1'b0;
            idx_r   <= {IDXW{1'b0}};
            valid_r <= 1'b0;
        end else if (in_valid) begin
            eq_r    <= eq_s;
            neq_r   <= neq_s;
            idx_r   <= idx_s;
            valid_r <= 1'b1;
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign eq_q      = eq_r;
    assign neq_q     = neq_r;
    assign idx_q     = idx_r;
    assign out_valid = valid_r;

`ifdef EQUALITY_CHECKER_STICKY_EN
    logic sticky_r;

    // Sticky mismatch flag: a qualified mismatch beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_r <= 1'b0;
        end else if (in_valid && neq_s) begin
            sticky_r <= 1'b1;
        end else if (sticky_clr) begin
            sticky_r <= 1'b0;
        end else begin
            sticky_r <= sticky_r;
        end
    end

    assign sticky_neq = sticky_r;
`endif

endmodule

// File: tb/tb_equality_checker.sv
// Self-checking bench for equality_checker: N=32 instance with a scoreboard on the registered stage, plus an N=1 instance.
module tb_equality_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        in_valid;
    logic        eq, neq, eq_q, neq_q, out_valid;
    logic [4:0]  diff_idx, idx_q;

    logic        a1, b1, in_valid1;
    logic        eq1, neq1, eq_q1, neq_q1, ov1;
    logic [0:0]  idx1, idx_q1;

`ifdef EQUALITY_CHECKER_STICKY_EN
    logic        sticky_clr, sticky_neq;
    logic        sticky_clr1, sticky_neq1;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       eq;
        logic       neq;
        logic [4:0] idx;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    equality_checker #(.N(32)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
`ifdef EQUALITY_CHECKER_STICKY_EN
        .sticky_clr(sticky_clr), .sticky_neq(sticky_neq),
`endif
        .eq(eq), .neq(neq), .diff_idx(diff_idx),
        .eq_q(eq_q), .neq_q(neq_q), .idx_q(idx_q), .out_valid(out_valid)
    );

    equality_checker #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(in_valid1),
`ifdef EQUALITY_CHECKER_STICKY_EN
        .sticky_clr(sticky_clr1), .sticky_neq(sticky_neq1),
`endif
        .eq(eq1), .neq(neq1), .diff_idx(idx1),
        .eq_q(eq_q1), .neq_q(neq_q1), .idx_q(idx_q1), .out_valid(ov1)
    );

    // Reference: lowest index where the operands differ, 0 when equal.
    function automatic logic [4:0] model_idx(input logic [31:0] x);
        for (int i = 0; i < 32; i++) begin
            if (x[i]) return i[4:0];
        end
        return 5'd0;
    endfunction

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e.eq  = (x == y);
        e.neq = (x != y);
        e.idx = model_idx(x ^ y);
        return e;
    endfunction

    task automatic test_reset();
        exp_t e;
        @(negedge clk);
        rst = 1'b0; a = 32'd5; b = 32'd5; in_valid = 1'b1;
        sb_q.push_back(model(a, b));
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || sb_q.size() == 0) begin
            errors++; $display("FAIL pre_reset_valid out_valid=%b queued=%0d need 1", out_valid, sb_q.size());
        end else begin
            e = sb_q.pop_front();
            checks++;
            if ({eq_q, neq_q, idx_q} !== {e.eq, e.neq, e.idx}) begin
                errors++; $display("FAIL pre_reset_regs got %b need %b", {eq_q, neq_q, idx_q}, {e.eq, e.neq, e.idx});
            end
        end
        rst = 1'b1; a = 32'd3; b = 32'd6; in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({eq, neq} !== 2'b01) begin
                errors++; $display("FAIL reset_comb_track cycle %0d got eq/neq=%b need 01", k, {eq, neq});
            end
            @(negedge clk);
            checks++;
            if ({eq_q, neq_q, idx_q, out_valid} !== 8'd0) begin
                errors++; $display("FAIL reset_regs cycle %0d got %b need 00000000", k, {eq_q, neq_q, idx_q, out_valid});
            end
        end
        rst = 1'b0; in_valid = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_walking();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            a = 32'd0; b = 32'd0; a[i] = 1'b1; b[i] = 1'b1;
            #1;
            checks++;
            if ({eq, neq, diff_idx} !== {1'b1, 1'b0, 5'd0}) begin
                errors++; $display("FAIL walk_equal bit %0d got %b need 1000000", i, {eq, neq, diff_idx});
            end
            b[i] = 1'b0;
            #1;
            checks++;
            if ({eq, neq, diff_idx} !== {1'b0, 1'b1, i[4:0]}) begin
                errors++; $display("FAIL walk_diff bit %0d got %b need %b", i, {eq, neq, diff_idx}, {1'b0, 1'b1, i[4:0]});
            end
            a[i] = 1'b0;
            #1;
            checks++;
            if ({eq, neq} !== 2'b10) begin
                errors++; $display("FAIL walk_zero bit %0d got %b need 10", i, {eq, neq});
            end
        end
    endtask

    task automatic test_patterns();
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'h7FFF_FFFF;
        #1;
        checks++;
        if ({eq, neq, diff_idx} !== {1'b0, 1'b1, 5'd31}) begin
            errors++; $display("FAIL msb_diff got %b need 0111111", {eq, neq, diff_idx});
        end
        a = 32'hA5A5_A5A5; b = 32'hA5A5_A5A5;
        #1;
        checks++;
        if ({eq, neq, diff_idx} !== {1'b1, 1'b0, 5'd0}) begin
            errors++; $display("FAIL a5_equal got %b need 1000000", {eq, neq, diff_idx});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa[3] = '{32'd1, 32'd1, 32'd8};
        logic [31:0] pb[3] = '{32'd1, 32'd3, 32'd0};
        exp_t        want[3] = '{'{1'b1, 1'b0, 5'd0}, '{1'b0, 1'b1, 5'd1}, '{1'b0, 1'b1, 5'd3}};
        exp_t        e;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (out_valid !== 1'b1 || sb_q.size() == 0) begin
                    errors++; $display("FAIL b2b_valid beat %0d out_valid=%b need 1", k - 1, out_valid);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if ({eq_q, neq_q, idx_q} !== {e.eq, e.neq, e.idx}) begin
                        errors++; $display("FAIL b2b_result beat %0d got %b need %b", k - 1, {eq_q, neq_q, idx_q}, {e.eq, e.neq, e.idx});
                    end
                end
            end
            if (k < 3) begin
                a = pa[k]; b = pb[k]; in_valid = 1'b1;
                sb_q.push_back(want[k]);
            end else begin
                a = 32'hDEAD_BEEF; b = 32'h0; in_valid = 1'b0;
            end
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({out_valid, eq_q, neq_q, idx_q} !== {1'b0, 1'b0, 1'b1, 5'd3}) begin
                errors++; $display("FAIL b2b_hold got %b need 00100011", {out_valid, eq_q, neq_q, idx_q});
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic [31:0] x, y;
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (out_valid !== 1'b1 || sb_q.size() == 0) begin
                    errors++; $display("FAIL rand_valid beat %0d out_valid=%b need 1", k - 1, out_valid);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if ({eq_q, neq_q, idx_q} !== {e.eq, e.neq, e.idx}) begin
                        errors++; $display("FAIL rand_result beat %0d got %b need %b", k - 1, {eq_q, neq_q, idx_q}, {e.eq, e.neq, e.idx});
                    end
                end
            end
            if (k < 24) begin
                x = $urandom;
                case (k % 3)
                    0:       y = x;
                    1:       y = x ^ (32'd1 << $urandom_range(31, 0));
                    default: y = $urandom;
                endcase
                a = x; b = y; in_valid = 1'b1;
                e = model(x, y);
                sb_q.push_back(e);
                #1;
                checks++;
                if ({eq, neq, diff_idx} !== {e.eq, e.neq, e.idx}) begin
                    errors++; $display("FAIL rand_comb a=%h b=%h got %b need %b", x, y, {eq, neq, diff_idx}, {e.eq, e.neq, e.idx});
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL rand_drain leftover=%0d need 0", sb_q.size());
        end
        sb_q.delete();
    endtask

`ifdef EQUALITY_CHECKER_STICKY_EN
    task automatic test_sticky();
        @(negedge clk);
        a = 32'd4; b = 32'd0; in_valid = 1'b1; sticky_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (sticky_neq !== 1'b1) begin
            errors++; $display("FAIL sticky_set got %b need 1", sticky_neq);
        end
        a = 32'd7; b = 32'd7;
        repeat (2) @(negedge clk);
        checks++;
        if (sticky_neq !== 1'b1) begin
            errors++; $display("FAIL sticky_hold got %b need 1", sticky_neq);
        end
        in_valid = 1'b0; sticky_clr = 1'b1;
        @(negedge clk);
        checks++;
        if (sticky_neq !== 1'b0) begin
            errors++; $display("FAIL sticky_clear got %b need 0", sticky_neq);
        end
        a = 32'd1; b = 32'd2; in_valid = 1'b1; sticky_clr = 1'b1;
        @(negedge clk);
        checks++;
        if (sticky_neq !== 1'b1) begin
            errors++; $display("FAIL sticky_set_wins got %b need 1", sticky_neq);
        end
        in_valid = 1'b0; sticky_clr = 1'b0;
    endtask
`endif

    task automatic test_n1();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a1 = k[1]; b1 = k[0];
            #1;
            checks++;
            if ({eq1, neq1, idx1} !== {(k[1] == k[0]), (k[1] != k[0]), 1'b0}) begin
                errors++; $display("FAIL n1_comb a=%b b=%b got %b need %b", k[1], k[0], {eq1, neq1, idx1}, {(k[1] == k[0]), (k[1] != k[0]), 1'b0});
            end
        end
    endtask

    initial begin
        rst = 1'b1; a = 32'd0; b = 32'd0; in_valid = 1'b0;
        a1 = 1'b0; b1 = 1'b0; in_valid1 = 1'b0;
`ifdef EQUALITY_CHECKER_STICKY_EN
        sticky_clr = 1'b0; sticky_clr1 = 1'b0;
`endif
        repeat (2) @(negedge clk);
        test_reset();
        test_walking();
        test_patterns();
        test_back_to_back();
        test_random();
`ifdef EQUALITY_CHECKER_STICKY_EN
        test_sticky();
`endif
        test_n1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
